// File: rtl/bsg_clk_gen_pearl_monitor_pkg.sv
// bsg_clk_gen_pearl_monitor_pkg
//   Shared types for the programmable clock-monitor divider.
//   - bsg_clk_gen_pearl_monitor_mode_e : output mode encoding (off/divide/pulse/rsvd)
//   - reset_mode_lp                    : mode loaded on reset (divide)
package bsg_clk_gen_pearl_monitor_pkg;

  typedef enum logic [1:0] {
    e_mon_off    = 2'd0,
    e_mon_divide = 2'd1,
    e_mon_pulse  = 2'd2,
    e_mon_rsvd   = 2'd3
  } bsg_clk_gen_pearl_monitor_mode_e;

  localparam bsg_clk_gen_pearl_monitor_mode_e reset_mode_lp = e_mon_divide;

endpackage

// File: rtl/bsg_clk_gen_pearl_monitor_period_ctr.sv
// bsg_clk_gen_pearl_monitor_period_ctr
//   Counts rising edges of the registered monitor output. The edge is seen
//   one cycle after the monitor flop rises. The counter wraps naturally and
//   a synchronous clear overrides a simultaneous increment.
// Ports:
//   clk_i    - monitored clock
//   reset_i  - asynchronous active-high reset
//   mon_i    - registered monitor output to watch
//   clear_i  - synchronous clear of the count
//   count_o  - number of observed 0->1 transitions
module bsg_clk_gen_pearl_monitor_period_ctr
  import bsg_clk_gen_pearl_monitor_pkg::*;
#(
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     mon_i,
  input  logic                     clear_i,
  output logic [count_width_p-1:0] count_o
);

  logic                     prev_r;
  logic [count_width_p-1:0] count_r;
  logic                     rise;

  assign rise = mon_i & ~prev_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prev_r  <= 1'b0;
      count_r <= '0;
    end else begin
      prev_r <= mon_i;
      if (clear_i)
        count_r <= '0;
      else if (rise)
        count_r <= count_r + count_width_p'(1);
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/bsg_clk_gen_pearl_monitor_divn.sv
// bsg_clk_gen_pearl_monitor_divn
//   Runtime-programmable divider for the chip monitor pin. Supports divide
//   (50% duty, period 2(N+1)), pulse (one high cycle every N+1) and off.
//   New configurations wait in a pending register until a glitch-free
//   apply point; a config arriving exactly at an apply point bypasses it.
//   Optional period counter is built only when the macro
//   BSG_CLK_GEN_PEARL_MONITOR_PERIOD_CNT_EN is defined; otherwise
//   period_cnt_o is 0 and clear_i is ignored.
// Ports:
//   clk_i, reset_i  - clock and asynchronous active-high reset
//   cfg_v_i         - new config valid (always accepted)
//   cfg_mode_i      - 0 off, 1 divide, 2 pulse, 3 reserved (acts as off)
//   cfg_div_i       - divider value N
//   cfg_pending_o   - a config is waiting for its apply point
//   clear_i         - synchronous clear of period_cnt_o
//   clk_monitor_o   - registered monitor output
//   period_cnt_o    - count of monitor rising edges
module bsg_clk_gen_pearl_monitor_divn
  import bsg_clk_gen_pearl_monitor_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int reset_div_p   = 14,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cfg_v_i,
  input  logic [1:0]               cfg_mode_i,
  input  logic [width_p-1:0]       cfg_div_i,
  output logic                     cfg_pending_o,
  input  logic                     clear_i,
  output logic                     clk_monitor_o,
  output logic [count_width_p-1:0] period_cnt_o
);

  bsg_clk_gen_pearl_monitor_mode_e mode_r, mode_n;
  bsg_clk_gen_pearl_monitor_mode_e pend_mode_r, pend_mode_n;
  logic [width_p-1:0] div_r, div_n;
  logic [width_p-1:0] cnt_r, cnt_n;
  logic [width_p-1:0] pend_div_r, pend_div_n;
  logic               pend_v_r, pend_v_n;
  logic               mon_r, mon_n;
  logic               at_terminal;
  logic               boundary;
  logic               apply;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_r      <= reset_mode_lp;
      div_r       <= width_p'(reset_div_p);
      cnt_r       <= '0;
      mon_r       <= 1'b0;
      pend_v_r    <= 1'b0;
      pend_mode_r <= e_mon_off;
      pend_div_r  <= '0;
    end else begin
      mode_r      <= mode_n;
      div_r       <= div_n;
      cnt_r       <= cnt_n;
      mon_r       <= mon_n;
      pend_v_r    <= pend_v_n;
      pend_mode_r <= pend_mode_n;
      pend_div_r  <= pend_div_n;
    end
  end

  // Next-state logic. The apply point in divide mode is the last cycle of a
  // high phase, so the output falls on the switching edge and the new ratio
  // starts a clean low phase. Off/reserved modes have nothing to protect and
  // apply as soon as a pending config exists.
  always_comb begin
    at_terminal = (cnt_r == div_r);

    mode_n      = mode_r;
    div_n       = div_r;
    pend_v_n    = pend_v_r;
    pend_mode_n = pend_mode_r;
    pend_div_n  = pend_div_r;

    case (mode_r)
      e_mon_divide: begin
        boundary = at_terminal & mon_r;
        cnt_n    = at_terminal ? '0 : cnt_r + width_p'(1);
        mon_n    = at_terminal ? ~mon_r : mon_r;
      end
      e_mon_pulse: begin
        boundary = at_terminal;
        cnt_n    = at_terminal ? '0 : cnt_r + width_p'(1);
        mon_n    = at_terminal;
      end
      default: begin
        boundary = pend_v_r;
        cnt_n    = '0;
        mon_n    = 1'b0;
      end
    endcase

    apply = boundary & (pend_v_r | cfg_v_i);

    if (apply) begin
      cnt_n    = '0;
      pend_v_n = 1'b0;
      // An incoming config is newer than anything pending, so it wins.
      if (cfg_v_i) begin
        mode_n = bsg_clk_gen_pearl_monitor_mode_e'(cfg_mode_i);
        div_n  = cfg_div_i;
      end else begin
        mode_n = pend_mode_r;
        div_n  = pend_div_r;
      end
    end else if (cfg_v_i) begin
      pend_v_n    = 1'b1;
      pend_mode_n = bsg_clk_gen_pearl_monitor_mode_e'(cfg_mode_i);
      pend_div_n  = cfg_div_i;
    end
  end

  // Outputs come straight from flops
  always_comb begin
    clk_monitor_o = mon_r;
    cfg_pending_o = pend_v_r;
  end

`ifdef BSG_CLK_GEN_PEARL_MONITOR_PERIOD_CNT_EN
  bsg_clk_gen_pearl_monitor_period_ctr #(
    .count_width_p(count_width_p)
  ) period_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .mon_i   (mon_r),
    .clear_i (clear_i),
    .count_o (period_cnt_o)
  );
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign period_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_clk_gen_pearl_monitor_divn.sv
// tb_bsg_clk_gen_pearl_monitor_divn
//   Scoreboard bench: the stimulus process pushes expected output values
//   tagged with the cycle at which they must hold; monitor processes compare
//   them at the falling clock edge (or at reset release for reset entries).
//   A second DUT instance with a 4-bit period counter shares all inputs and
//   shows counter wrap.
module tb_bsg_clk_gen_pearl_monitor_divn;

`ifdef BSG_CLK_GEN_PEARL_MONITOR_PERIOD_CNT_EN
  localparam bit cnt_en_lp = 1'b1;
`else
  localparam bit cnt_en_lp = 1'b0;
`endif

  logic        clk_i;
  logic        reset_i;
  logic        cfg_v_i;
  logic [1:0]  cfg_mode_i;
  logic [7:0]  cfg_div_i;
  logic        clear_i;
  logic        cfg_pending_o;
  logic        clk_monitor_o;
  logic [15:0] period_cnt_o;
  logic        pend4;
  logic        mon4;
  logic [3:0]  cnt4;

  bsg_clk_gen_pearl_monitor_divn #(
    .width_p(8), .reset_div_p(14), .count_width_p(16)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .cfg_v_i       (cfg_v_i),
    .cfg_mode_i    (cfg_mode_i),
    .cfg_div_i     (cfg_div_i),
    .cfg_pending_o (cfg_pending_o),
    .clear_i       (clear_i),
    .clk_monitor_o (clk_monitor_o),
    .period_cnt_o  (period_cnt_o)
  );

  bsg_clk_gen_pearl_monitor_divn #(
    .width_p(8), .reset_div_p(14), .count_width_p(4)
  ) dut4 (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .cfg_v_i       (cfg_v_i),
    .cfg_mode_i    (cfg_mode_i),
    .cfg_div_i     (cfg_div_i),
    .cfg_pending_o (pend4),
    .clear_i       (clear_i),
    .clk_monitor_o (mon4),
    .period_cnt_o  (cnt4)
  );

  typedef struct {
    int          at;
    bit          on_reset;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   b;
  int   b2;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [15:0] cnt_exp(input int v);
    return cnt_en_lp ? 16'(v) : 16'(0);
  endfunction

  task automatic push_exp(input int at, input bit on_reset, input int kind,
                          input logic [15:0] val, input string name);
    exp_t e;
    e.at = at; e.on_reset = on_reset; e.kind = kind; e.val = val; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic expect_mon(input int at, input logic v, input string name);
    push_exp(at, 1'b0, 0, {15'd0, v}, name);
  endtask

  task automatic expect_pend(input int at, input logic v, input string name);
    push_exp(at, 1'b0, 1, {15'd0, v}, name);
  endtask

  task automatic expect_cnt(input int at, input int v, input string name);
    push_exp(at, 1'b0, 2, cnt_exp(v), name);
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    case (e.kind)
      0: if (clk_monitor_o !== e.val[0] || mon4 !== e.val[0]) begin
           errors++;
           $display("[TB] FAIL %s cyc=%0d: clk_monitor_o=%0b/%0b expected %0b",
                    e.name, cyc, clk_monitor_o, mon4, e.val[0]);
         end
      1: if (cfg_pending_o !== e.val[0] || pend4 !== e.val[0]) begin
           errors++;
           $display("[TB] FAIL %s cyc=%0d: cfg_pending_o=%0b/%0b expected %0b",
                    e.name, cyc, cfg_pending_o, pend4, e.val[0]);
         end
      default: if (period_cnt_o !== e.val || cnt4 !== e.val[3:0]) begin
           errors++;
           $display("[TB] FAIL %s cyc=%0d: period_cnt_o=%0d (4-bit %0d) expected %0d (4-bit %0d)",
                    e.name, cyc, period_cnt_o, cnt4, e.val, e.val[3:0]);
         end
    endcase
  endtask

  // Cycle-tagged expectations are compared away from the active edge
  always @(negedge clk_i) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (!sb_q[i].on_reset && sb_q[i].at == cyc) begin
        check_output(sb_q[i]);
        sb_q.delete(i);
      end
    end
  end

  // Reset expectations are compared at release, before any clock edge
  always @(negedge reset_i) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].on_reset) begin
        check_output(sb_q[i]);
        sb_q.delete(i);
      end
    end
  end

  task automatic goto_cyc(input int at);
    if (cyc < at) begin
      while (cyc < at) @(negedge clk_i);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int at, input logic v, input logic [1:0] mode,
                                input logic [7:0] div, input logic clr);
    goto_cyc(at);
    cfg_v_i    = v;
    cfg_mode_i = mode;
    cfg_div_i  = div;
    clear_i    = clr;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i    = 1'b1;
    cfg_v_i    = 1'b0;
    cfg_mode_i = 2'd0;
    cfg_div_i  = 8'd0;
    clear_i    = 1'b0;

    push_exp(0, 1'b1, 0, 16'd0, "reset_mon");
    push_exp(0, 1'b1, 1, 16'd0, "reset_pend");
    push_exp(0, 1'b1, 2, 16'd0, "reset_cnt");
    repeat (2) @(negedge clk_i);
    #1 reset_i = 1'b0;
    b = cyc;

    // Reset default: divide by 30
    expect_mon(b + 14, 1'b0, "div30_pre_rise");
    expect_mon(b + 15, 1'b1, "div30_first_rise");
    expect_cnt(b + 15, 0, "cnt_before_first_edge");
    expect_cnt(b + 16, 1, "cnt_first_edge");
    expect_mon(b + 29, 1'b1, "div30_high_end");
    expect_mon(b + 30, 1'b0, "div30_fall");
    expect_mon(b + 45, 1'b1, "div30_second_rise");
    expect_cnt(b + 90, 3, "cnt_after_90");

    // Divide N=0: pending until end of a high phase
    expect_pend(b + 91, 1'b1, "n0_pending_set");
    expect_pend(b + 119, 1'b1, "n0_pending_held");
    expect_mon(b + 119, 1'b1, "n0_last_high");
    expect_pend(b + 120, 1'b0, "n0_pending_clear");
    expect_mon(b + 120, 1'b0, "n0_apply_low");
    expect_mon(b + 121, 1'b1, "n0_div2_high");
    expect_mon(b + 122, 1'b0, "n0_div2_low");
    apply_stimulus(b + 90, 1'b1, 2'd1, 8'd0, 1'b0);
    apply_stimulus(b + 91, 1'b0, 2'd0, 8'd0, 1'b0);

    // Divide N=3
    expect_pend(b + 123, 1'b1, "n3_pending");
    expect_mon(b + 123, 1'b1, "n3_last_div2_high");
    expect_pend(b + 124, 1'b0, "n3_applied");
    expect_mon(b + 124, 1'b0, "n3_apply_low");
    expect_mon(b + 127, 1'b0, "n3_low_end");
    expect_mon(b + 128, 1'b1, "n3_rise");
    expect_mon(b + 131, 1'b1, "n3_high_end");
    expect_mon(b + 132, 1'b0, "n3_fall");
    expect_mon(b + 136, 1'b1, "n3_rise2");
    apply_stimulus(b + 122, 1'b1, 2'd1, 8'd3, 1'b0);
    apply_stimulus(b + 123, 1'b0, 2'd0, 8'd0, 1'b0);

    // Pulse N=4, config lands exactly on the apply point (bypass)
    expect_pend(b + 140, 1'b0, "bypass_no_pending");
    expect_mon(b + 140, 1'b0, "bypass_low");
    expect_cnt(b + 140, 8, "cnt_at_140");
    expect_mon(b + 144, 1'b0, "p4_low");
    expect_mon(b + 145, 1'b1, "p4_pulse");
    expect_mon(b + 146, 1'b0, "p4_after_pulse");
    expect_mon(b + 149, 1'b0, "p4_low2");
    expect_mon(b + 150, 1'b1, "p4_pulse2");
    apply_stimulus(b + 139, 1'b1, 2'd2, 8'd4, 1'b0);
    apply_stimulus(b + 140, 1'b0, 2'd0, 8'd0, 1'b0);

    // Pulse N=0: constant high
    expect_pend(b + 151, 1'b1, "p0_pending");
    expect_pend(b + 154, 1'b1, "p0_pending_held");
    expect_mon(b + 154, 1'b0, "p0_wait_low");
    expect_pend(b + 155, 1'b0, "p0_applied");
    expect_mon(b + 155, 1'b1, "p0_apply_pulse");
    expect_mon(b + 156, 1'b1, "p0_const1");
    expect_mon(b + 160, 1'b1, "p0_const1_late");
    expect_cnt(b + 160, 11, "cnt_at_160");
    apply_stimulus(b + 150, 1'b1, 2'd2, 8'd0, 1'b0);
    apply_stimulus(b + 151, 1'b0, 2'd0, 8'd0, 1'b0);

    // Reserved mode behaves as off
    expect_pend(b + 161, 1'b0, "rsvd_bypass");
    expect_mon(b + 161, 1'b1, "rsvd_last_pulse");
    expect_mon(b + 162, 1'b0, "rsvd_off");
    expect_mon(b + 165, 1'b0, "rsvd_held_off");
    apply_stimulus(b + 160, 1'b1, 2'd3, 8'd7, 1'b0);
    apply_stimulus(b + 161, 1'b0, 2'd0, 8'd0, 1'b0);

    // From off: apply on the first pending cycle, counter restarts at 0
    expect_pend(b + 166, 1'b1, "off_pending");
    expect_pend(b + 167, 1'b0, "off_applied");
    expect_mon(b + 170, 1'b0, "off_to_n3_low");
    expect_mon(b + 171, 1'b1, "off_to_n3_rise");
    apply_stimulus(b + 165, 1'b1, 2'd1, 8'd3, 1'b0);
    apply_stimulus(b + 166, 1'b0, 2'd0, 8'd0, 1'b0);

    // Two configs in one period: last one wins
    expect_pend(b + 172, 1'b1, "lastwin_pending");
    expect_pend(b + 174, 1'b1, "lastwin_pending_held");
    expect_pend(b + 175, 1'b0, "lastwin_applied");
    expect_mon(b + 175, 1'b0, "lastwin_apply_low");
    expect_mon(b + 181, 1'b0, "lastwin_not_div5");
    expect_mon(b + 184, 1'b0, "lastwin_low_end");
    expect_mon(b + 185, 1'b1, "lastwin_div9_rise");
    expect_mon(b + 194, 1'b1, "lastwin_div9_high_end");
    expect_mon(b + 195, 1'b0, "lastwin_div9_fall");
    expect_cnt(b + 196, 13, "cnt_at_196");
    apply_stimulus(b + 171, 1'b1, 2'd1, 8'd5, 1'b0);
    apply_stimulus(b + 172, 1'b1, 2'd1, 8'd9, 1'b0);
    apply_stimulus(b + 173, 1'b0, 2'd0, 8'd0, 1'b0);

    // Clear coinciding with a counted rising edge
    expect_mon(b + 205, 1'b1, "clear_rise");
    expect_cnt(b + 205, 13, "cnt_before_clear");
    expect_cnt(b + 206, 0, "clear_wins");
    expect_cnt(b + 207, 0, "clear_holds");
    apply_stimulus(b + 205, 1'b0, 2'd0, 8'd0, 1'b1);

    // Divide N=0 for 16 edges: 4-bit counter wraps
    expect_pend(b + 207, 1'b1, "wrap_cfg_pending");
    expect_pend(b + 214, 1'b1, "wrap_cfg_held");
    expect_pend(b + 215, 1'b0, "wrap_cfg_applied");
    expect_mon(b + 215, 1'b0, "wrap_apply_low");
    expect_mon(b + 216, 1'b1, "wrap_div2_high");
    expect_mon(b + 217, 1'b0, "wrap_div2_low");
    expect_cnt(b + 246, 15, "cnt_15_edges");
    expect_cnt(b + 247, 16, "cnt_16_edges_wrap");
    apply_stimulus(b + 206, 1'b1, 2'd1, 8'd0, 1'b0);
    apply_stimulus(b + 207, 1'b0, 2'd0, 8'd0, 1'b0);

    // Asynchronous reset between clock edges while high with a pending config
    expect_mon(b + 248, 1'b1, "prereset_high");
    expect_pend(b + 248, 1'b1, "prereset_pending");
    expect_cnt(b + 248, 16, "prereset_cnt");
    apply_stimulus(b + 247, 1'b1, 2'd1, 8'd5, 1'b0);
    apply_stimulus(b + 248, 1'b0, 2'd0, 8'd0, 1'b0);
    push_exp(0, 1'b1, 0, 16'd0, "async_reset_mon");
    push_exp(0, 1'b1, 1, 16'd0, "async_reset_pend");
    push_exp(0, 1'b1, 2, 16'd0, "async_reset_cnt");
    #1 reset_i = 1'b1;
    #2 reset_i = 1'b0;
    b2 = cyc;

    expect_mon(b2 + 1, 1'b0, "postreset_mon");
    expect_pend(b2 + 1, 1'b0, "postreset_pend");
    expect_cnt(b2 + 1, 0, "postreset_cnt");
    expect_mon(b2 + 14, 1'b0, "postreset_pre_rise");
    expect_mon(b2 + 15, 1'b1, "postreset_rise");
    expect_cnt(b2 + 15, 0, "postreset_cnt_pre_edge");
    expect_cnt(b2 + 16, 1, "postreset_cnt_edge");
    expect_mon(b2 + 29, 1'b1, "postreset_high_end");
    expect_mon(b2 + 30, 1'b0, "postreset_fall");

    goto_cyc(b2 + 33);

    for (int i = 0; i < sb_q.size(); i++) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: expectation at cyc %0d never compared, required value %0d",
               sb_q[i].name, sb_q[i].at, sb_q[i].val);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
